// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/MEM requesters, the arbiter and the single RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        err;
    logic [7:0]  timeout_cnt;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               err, timeout_cnt
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               err, timeout_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch (I) and data load/store (D).
// D has priority; a streak counter bounds I starvation and a timer aborts dead grants.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state, state_next;
    logic [3:0] streak, streak_next;
    logic [7:0] timer, timer_next;
    logic       err_q, err_next;
    logic       d_req;
    logic       responded;

    assign d_req     = bus.dREN | bus.dWEN;
    assign responded = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);

    always_comb begin
        state_next   = state;
        streak_next  = streak;
        timer_next   = timer;
        err_next     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req;
        bus.iload    = 32'h0;
        bus.dload    = 32'h0;

        case (state)
            IDLE: begin
                timer_next = 8'h0;
                if (d_req && (!bus.iREN || (streak < STREAK_MAX)))
                    state_next = DGNT;
                else if (bus.iREN)
                    state_next = IGNT;
            end

            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!d_req) begin
                    state_next = IDLE;
                    timer_next = 8'h0;
                end else if (responded) begin
                    bus.dwait  = 1'b0;
                    bus.dload  = bus.dWEN ? 32'h0 : bus.ramload;
                    state_next = IDLE;
                    timer_next = 8'h0;
                    err_next   = (bus.ramstate == RAM_ERROR);
                    // Only D completions with I waiting count toward starvation.
                    if (bus.iREN)
                        streak_next = (streak < STREAK_MAX) ? streak + 4'd1 : STREAK_MAX;
                    else
                        streak_next = 4'd0;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                    timer_next = 8'h0;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end

            IGNT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_next = IDLE;
                    timer_next = 8'h0;
                end else if (responded) begin
                    bus.iwait   = 1'b0;
                    bus.iload   = bus.ramload;
                    state_next  = IDLE;
                    timer_next  = 8'h0;
                    err_next    = (bus.ramstate == RAM_ERROR);
                    streak_next = 4'd0;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                    timer_next = 8'h0;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
                timer_next = 8'h0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= 4'd0;
            timer  <= 8'h0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
            timer  <= timer_next;
            err_q  <= err_next;
        end
    end

    assign bus.err         = err_q;
    assign bus.timeout_cnt = timer;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, D priority, starvation bound, timeout, ERROR, reset.
module tb_mem_arbiter;
    logic CLK;
    logic nRST;
    int   n_cmp;
    int   n_fail;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_next();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = 2'd0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        nRST   = 1'b0;
        clear_inputs();
        #12;
        chk("rst_ramREN", {31'b0, bus.ramREN}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        chk("rst_timer", {24'b0, bus.timeout_cnt}, 32'd0);
        chk("rst_streak", {28'b0, dut.streak}, 32'd0);

        // Single instruction fetch, one-cycle ACCESS.
        do_reset();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        sample();
        chk("f_c0_ramREN", {31'b0, bus.ramREN}, 32'd0);
        chk("f_c0_iwait", {31'b0, bus.iwait}, 32'd1);
        edge_next();
        bus.ramstate = 2'd2;
        bus.ramload  = 32'h8C010004;
        sample();
        chk("f_c1_ramREN", {31'b0, bus.ramREN}, 32'd1);
        chk("f_c1_ramaddr", bus.ramaddr, 32'h40);
        chk("f_c1_iwait", {31'b0, bus.iwait}, 32'd0);
        chk("f_c1_iload", bus.iload, 32'h8C010004);
        edge_next();
        bus.iREN     = 1'b0;
        bus.ramstate = 2'd0;
        sample();
        chk("f_c2_idle", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("f_c2_err", {31'b0, bus.err}, 32'd0);

        // I and D write together: D first after two BUSY cycles, then I.
        do_reset();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h44;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.dstore   = 32'hDEADBEEF;
        bus.ramstate = 2'd1;
        sample();
        chk("c_c0_dwait", {31'b0, bus.dwait}, 32'd1);
        edge_next();
        sample();
        chk("c_c1_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
        chk("c_c1_ramstore", bus.ramstore, 32'hDEADBEEF);
        chk("c_c1_ramaddr", bus.ramaddr, 32'h100);
        chk("c_c1_dwait", {31'b0, bus.dwait}, 32'd1);
        chk("c_c1_iwait", {31'b0, bus.iwait}, 32'd1);
        chk("c_c1_timer", {24'b0, bus.timeout_cnt}, 32'd0);
        edge_next();
        sample();
        chk("c_c2_dwait", {31'b0, bus.dwait}, 32'd1);
        chk("c_c2_timer", {24'b0, bus.timeout_cnt}, 32'd1);
        edge_next();
        bus.ramstate = 2'd2;
        sample();
        chk("c_c3_dwait", {31'b0, bus.dwait}, 32'd0);
        edge_next();
        bus.dWEN = 1'b0;
        sample();
        chk("c_c4_idle", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("c_c4_streak", {28'b0, dut.streak}, 32'd1);
        edge_next();
        bus.ramload = 32'h12345678;
        sample();
        chk("c_c5_ramREN", {31'b0, bus.ramREN}, 32'd1);
        chk("c_c5_ramaddr", bus.ramaddr, 32'h44);
        chk("c_c5_iwait", {31'b0, bus.iwait}, 32'd0);
        chk("c_c5_iload", bus.iload, 32'h12345678);
        edge_next();
        bus.iREN = 1'b0;
        sample();
        chk("c_c6_streak", {28'b0, dut.streak}, 32'd0);

        // Continuous D reads with I pending: four D grants, then I is forced.
        do_reset();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h80;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h200;
        bus.ramstate = 2'd2;
        bus.ramload  = 32'h11;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c % 2 == 0) begin
                chk($sformatf("s_c%0d_idle", c), {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
            end else if (c < 9) begin
                chk($sformatf("s_c%0d_daddr", c), bus.ramaddr, 32'h200);
                chk($sformatf("s_c%0d_dwait", c), {31'b0, bus.dwait}, 32'd0);
                chk($sformatf("s_c%0d_dload", c), bus.dload, 32'h11);
                chk($sformatf("s_c%0d_iwait", c), {31'b0, bus.iwait}, 32'd1);
            end else begin
                chk("s_c9_iaddr", bus.ramaddr, 32'h80);
                chk("s_c9_iwait", {31'b0, bus.iwait}, 32'd0);
                chk("s_c9_iload", bus.iload, 32'h11);
                chk("s_c9_dwait", {31'b0, bus.dwait}, 32'd1);
            end
            if (c == 8)
                chk("s_c8_streak", {28'b0, dut.streak}, 32'd4);
            edge_next();
        end
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        sample();
        chk("s_end_streak", {28'b0, dut.streak}, 32'd0);

        // RAM stuck BUSY: release after 8 grant cycles, err pulse, regrant.
        do_reset();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h90;
        bus.ramstate = 2'd1;
        sample();
        chk("t_c0_ramREN", {31'b0, bus.ramREN}, 32'd0);
        edge_next();
        for (int c = 1; c <= 8; c++) begin
            sample();
            chk($sformatf("t_c%0d_ramREN", c), {31'b0, bus.ramREN}, 32'd1);
            chk($sformatf("t_c%0d_timer", c), {24'b0, bus.timeout_cnt}, 32'(c - 1));
            chk($sformatf("t_c%0d_iwait", c), {31'b0, bus.iwait}, 32'd1);
            chk($sformatf("t_c%0d_err", c), {31'b0, bus.err}, 32'd0);
            edge_next();
        end
        sample();
        chk("t_c9_ramREN", {31'b0, bus.ramREN}, 32'd0);
        chk("t_c9_err", {31'b0, bus.err}, 32'd1);
        chk("t_c9_iwait", {31'b0, bus.iwait}, 32'd1);
        chk("t_c9_timer", {24'b0, bus.timeout_cnt}, 32'd0);
        edge_next();
        sample();
        chk("t_c10_ramREN", {31'b0, bus.ramREN}, 32'd1);
        chk("t_c10_err", {31'b0, bus.err}, 32'd0);
        edge_next();
        bus.iREN = 1'b0;

        // ERROR response during a D read grant.
        do_reset();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        sample();
        chk("e_c0_ramREN", {31'b0, bus.ramREN}, 32'd0);
        edge_next();
        bus.ramstate = 2'd3;
        bus.ramload  = 32'h55;
        sample();
        chk("e_c1_ramREN", {31'b0, bus.ramREN}, 32'd1);
        chk("e_c1_dwait", {31'b0, bus.dwait}, 32'd0);
        chk("e_c1_dload", bus.dload, 32'h55);
        chk("e_c1_err", {31'b0, bus.err}, 32'd0);
        edge_next();
        bus.dREN     = 1'b0;
        bus.ramstate = 2'd0;
        sample();
        chk("e_c2_err", {31'b0, bus.err}, 32'd1);
        chk("e_c2_ramREN", {31'b0, bus.ramREN}, 32'd0);
        edge_next();
        sample();
        chk("e_c3_err", {31'b0, bus.err}, 32'd0);

        // Reset asserted while a D write grant is active.
        do_reset();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'hA0;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h400;
        bus.dstore   = 32'h0F0F0F0F;
        bus.ramstate = 2'd2;
        edge_next();
        sample();
        chk("r_c1_dwait", {31'b0, bus.dwait}, 32'd0);
        edge_next();
        bus.ramstate = 2'd1;
        sample();
        chk("r_c2_streak", {28'b0, dut.streak}, 32'd1);
        edge_next();
        sample();
        chk("r_c3_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("r_rst_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
        chk("r_rst_err", {31'b0, bus.err}, 32'd0);
        do_reset();
        bus.iREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h400;
        bus.ramstate = 2'd1;
        sample();
        chk("r_post_idle", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("r_post_streak", {28'b0, dut.streak}, 32'd0);
        chk("r_post_err", {31'b0, bus.err}, 32'd0);
        edge_next();
        sample();
        chk("r_post_dgnt", {31'b0, bus.ramWEN}, 32'd1);
        edge_next();
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
